// File: rtl/fifo_rd_stream_if.sv
// Interface bundling the FIFO read port and the outgoing valid/ready stream.
//   fifo_ren   : FIFO read strobe (engine -> FIFO)
//   fifo_empty : FIFO empty flag (FIFO -> engine)
//   fifo_dout  : FIFO registered read data (FIFO -> engine)
//   m_valid    : stream data valid (engine -> consumer)
//   m_ready    : consumer ready (consumer -> engine)
//   m_data     : stream data (engine -> consumer)
// The master modport is the read engine; the slave modport is the FIFO plus consumer side.
interface fifo_rd_stream_if #(
  parameter int unsigned dw = 32
);
  logic          fifo_ren;
  logic          fifo_empty;
  logic [dw-1:0] fifo_dout;
  logic          m_valid;
  logic          m_ready;
  logic [dw-1:0] m_data;

  modport master (
    output fifo_ren,
    input  fifo_empty,
    input  fifo_dout,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  fifo_ren,
    output fifo_empty,
    output fifo_dout,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side engine for a synchronous FIFO with one-cycle registered read data.
// Pulls words from the FIFO and presents them as a valid/ready stream, hiding the
// read latency with a 2-entry output buffer so 1 word/cycle is sustained.
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   en        : read enable; 0 stops new FIFO reads, buffered/inflight words still drain
//   cnt_clr   : synchronous clear of the delivered-word counter (wins over increment)
//   cnt_words : saturating count of delivered words
//   bus       : FIFO read port + output stream (master modport)
module fifo_rd_stream #(
  parameter int unsigned dw = 32,
  parameter int unsigned cw = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 cnt_clr,
  output logic [cw-1:0]        cnt_words,
  fifo_rd_stream_if.master     bus
);

  logic [dw-1:0] head_q, head_d;
  logic [dw-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          inflight_q;
  logic [cw-1:0] cnt_q, cnt_d;

  logic          pop;
  logic          ren;
  logic [1:0]    occ;

  assign bus.m_valid = (count_q != 2'd0);
  assign bus.m_data  = head_q;
  assign pop         = bus.m_valid & bus.m_ready;

  // Occupancy after this cycle's pop, counting the word already in flight. count+inflight
  // never exceeds 2, so 2 bits are enough and pop never underflows it.
  assign occ = count_q + {1'b0, inflight_q} - {1'b0, pop};

  // rst_n gate keeps the strobe low while reset is held, even with the FIFO non-empty.
  assign ren          = rst_n & en & ~bus.fifo_empty & (occ <= 2'd1);
  assign bus.fifo_ren = ren;
  assign cnt_words    = cnt_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({pop, inflight_q})
      2'b01: begin
        // Capture only: fill the first free slot.
        if (count_q == 2'd0) begin
          head_d = bus.fifo_dout;
        end else begin
          tail_d = bus.fifo_dout;
        end
        count_d = count_q + 2'd1;
      end
      2'b10: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Pop and capture: remaining entry shifts to head, new word lands behind it.
        if (count_q == 2'd1) begin
          head_d = bus.fifo_dout;
        end else begin
          head_d = tail_q;
          tail_d = bus.fifo_dout;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (pop && (cnt_q != {cw{1'b1}})) begin
      cnt_d = cnt_q + cw'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= ren;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] cnt_words;

  fifo_rd_stream_if #(.dw(DW)) bus ();

  fifo_rd_stream #(.dw(DW), .cw(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cnt_clr   (cnt_clr),
    .cnt_words (cnt_words),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered dout, reset together with the DUT (discards contents).
  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= wr_ptr;
      bus.fifo_dout <= '0;
    end else if (bus.fifo_ren && !bus.fifo_empty) begin
      bus.fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Stream monitor and invariant watch, sampled on the falling edge.
  logic [DW-1:0] rx [0:127];
  int rx_n = 0;
  int viol = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        if (rx_n < 128) rx[rx_n] = bus.m_data;
        rx_n = rx_n + 1;
      end
      if (bus.fifo_ren && bus.fifo_empty) viol = viol + 1;
      if (int'(dut.count_q) + int'(dut.inflight_q) > 2) viol = viol + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    push(32'h5A);
    #1;
    n_cmp++; if (bus.fifo_ren !== 1'b0) begin n_err++;
      $display("FAIL reset_ren: got %b want 0", bus.fifo_ren); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 32'h0) begin n_err++;
      $display("FAIL reset_data: got %h want 0", bus.m_data); end
    n_cmp++; if (cnt_words !== 4'd0) begin n_err++;
      $display("FAIL reset_cnt: got %0d want 0", cnt_words); end
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_release_valid: got %b want 0", bus.m_valid); end
    step();
  endtask

  task automatic test_basic();
    logic [5:0]    e_ren;
    logic [5:0]    e_val;
    logic [DW-1:0] e_dat [0:5];
    int base;
    clear_cnt();
    base = rx_n;
    en = 1'b1;
    bus.m_ready = 1'b1;
    e_ren = 6'b000111;
    e_val = 6'b011100;
    for (int i = 0; i < 6; i++) e_dat[i] = '0;
    e_dat[2] = 32'h11; e_dat[3] = 32'h22; e_dat[4] = 32'h33;
    push(32'h11); push(32'h22); push(32'h33);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.fifo_ren !== e_ren[i]) begin n_err++;
        $display("FAIL basic_ren c%0d: got %b want %b", i, bus.fifo_ren, e_ren[i]); end
      n_cmp++; if (bus.m_valid !== e_val[i]) begin n_err++;
        $display("FAIL basic_valid c%0d: got %b want %b", i, bus.m_valid, e_val[i]); end
      if (e_val[i]) begin
        n_cmp++; if (bus.m_data !== e_dat[i]) begin n_err++;
          $display("FAIL basic_data c%0d: got %h want %h", i, bus.m_data, e_dat[i]); end
      end
      step();
    end
    n_cmp++; if (cnt_words !== 4'd3) begin n_err++;
      $display("FAIL basic_cnt: got %0d want 3", cnt_words); end
    n_cmp++; if (rx_n - base !== 3) begin n_err++;
      $display("FAIL basic_count: got %0d want 3", rx_n - base); end
  endtask

  task automatic test_backpressure();
    int base;
    int nren;
    clear_cnt();
    base = rx_n;
    bus.m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 8; i++) push(32'hA0 + i);
    nren = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.fifo_ren) nren++;
      step();
    end
    n_cmp++; if (nren !== 2) begin n_err++;
      $display("FAIL bp_reads: got %0d want 2", nren); end
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++;
      $display("FAIL bp_valid_held: got %b want 1", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 32'hA0) begin n_err++;
      $display("FAIL bp_data_held: got %h want a0", bus.m_data); end
    bus.m_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.fifo_ren !== 1'b1) begin n_err++;
      $display("FAIL bp_resume_ren: got %b want 1", bus.fifo_ren); end
    step();
    for (int i = 0; i < 7; i++) step();
    n_cmp++; if (rx_n - base !== 8) begin n_err++;
      $display("FAIL bp_no_gap: got %0d want 8 words in 8 cycles", rx_n - base); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rx[base+i] !== 32'hA0 + i) begin n_err++;
        $display("FAIL bp_order w%0d: got %h want %h", i, rx[base+i], 32'hA0 + i); end
    end
    n_cmp++; if (cnt_words !== 4'd8) begin n_err++;
      $display("FAIL bp_cnt: got %0d want 8", cnt_words); end
  endtask

  task automatic test_toggle();
    int base;
    clear_cnt();
    base = rx_n;
    for (int i = 0; i < 16; i++) push(32'hB0 + i);
    for (int c = 0; c < 100 && (rx_n - base) < 16; c++) begin
      bus.m_ready = (c % 2 == 0);
      step();
    end
    bus.m_ready = 1'b1;
    n_cmp++; if (rx_n - base !== 16) begin n_err++;
      $display("FAIL toggle_count: got %0d want 16", rx_n - base); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (rx[base+i] !== 32'hB0 + i) begin n_err++;
        $display("FAIL toggle_order w%0d: got %h want %h", i, rx[base+i], 32'hB0 + i); end
    end
    n_cmp++; if (viol !== 0) begin n_err++;
      $display("FAIL toggle_invariant: got %0d violations want 0", viol); end
    n_cmp++; if (cnt_words !== 4'd15) begin n_err++;
      $display("FAIL toggle_cnt_sat: got %0d want 15", cnt_words); end
  endtask

  task automatic test_en_drop();
    int base;
    int nren;
    clear_cnt();
    base = rx_n;
    bus.m_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hC0 + i);
    @(negedge clk);
    n_cmp++; if (bus.fifo_ren !== 1'b1) begin n_err++;
      $display("FAIL en_first_ren: got %b want 1", bus.fifo_ren); end
    step();
    en = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.fifo_ren !== 1'b0) begin n_err++;
      $display("FAIL en_off_ren: got %b want 0", bus.fifo_ren); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hC0) begin n_err++;
      $display("FAIL en_inflight: got v=%b d=%h want v=1 d=c0", bus.m_valid, bus.m_data); end
    step();
    nren = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.fifo_ren) nren++;
      step();
    end
    n_cmp++; if (nren !== 0) begin n_err++;
      $display("FAIL en_idle_reads: got %0d want 0", nren); end
    n_cmp++; if (rx_n - base !== 1) begin n_err++;
      $display("FAIL en_idle_words: got %0d want 1", rx_n - base); end
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.fifo_ren !== 1'b1) begin n_err++;
      $display("FAIL en_back_ren: got %b want 1", bus.fifo_ren); end
    step();
    for (int c = 0; c < 20 && (rx_n - base) < 4; c++) step();
    n_cmp++; if (rx_n - base !== 4) begin n_err++;
      $display("FAIL en_total: got %0d want 4", rx_n - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx[base+i] !== 32'hC0 + i) begin n_err++;
        $display("FAIL en_order w%0d: got %h want %h", i, rx[base+i], 32'hC0 + i); end
    end
  endtask

  task automatic test_saturate();
    int base;
    clear_cnt();
    base = rx_n;
    bus.m_ready = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 20; i++) push(32'h100 + i);
    for (int c = 0; c < 80 && (rx_n - base) < 20; c++) step();
    n_cmp++; if (rx_n - base !== 20) begin n_err++;
      $display("FAIL sat_count: got %0d want 20", rx_n - base); end
    n_cmp++; if (cnt_words !== 4'd15) begin n_err++;
      $display("FAIL sat_cnt: got %0d want 15", cnt_words); end
    push(32'hD0); push(32'hD1);
    step();
    step();
    cnt_clr = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++;
      $display("FAIL clr_pop_valid: got %b want 1", bus.m_valid); end
    step();
    cnt_clr = 1'b0;
    n_cmp++; if (cnt_words !== 4'd0) begin n_err++;
      $display("FAIL clr_with_pop: got %0d want 0", cnt_words); end
    step();
    n_cmp++; if (cnt_words !== 4'd1) begin n_err++;
      $display("FAIL clr_then_pop: got %0d want 1", cnt_words); end
  endtask

  task automatic test_reset_mid();
    int base;
    clear_cnt();
    bus.m_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hE0 + i);
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hE0) begin n_err++;
      $display("FAIL rmid_pre: got v=%b d=%h want v=1 d=e0", bus.m_valid, bus.m_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++;
      $display("FAIL rmid_valid: got %b want 0", bus.m_valid); end
    n_cmp++; if (dut.count_q !== 2'd0) begin n_err++;
      $display("FAIL rmid_count: got %0d want 0", dut.count_q); end
    step();
    rst_n = 1'b1;
    base = rx_n;
    bus.m_ready = 1'b1;
    push(32'hF0); push(32'hF1); push(32'hF2);
    @(negedge clk);
    n_cmp++; if (bus.fifo_ren !== 1'b1) begin n_err++;
      $display("FAIL rmid_ren: got %b want 1", bus.fifo_ren); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++;
      $display("FAIL rmid_lat1: got %b want 0", bus.m_valid); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hF0) begin n_err++;
      $display("FAIL rmid_lat2: got v=%b d=%h want v=1 d=f0", bus.m_valid, bus.m_data); end
    step();
    for (int c = 0; c < 20 && (rx_n - base) < 3; c++) step();
    n_cmp++; if (rx_n - base !== 3) begin n_err++;
      $display("FAIL rmid_total: got %0d want 3", rx_n - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rx[base+i] !== 32'hF0 + i) begin n_err++;
        $display("FAIL rmid_order w%0d: got %h want %h", i, rx[base+i], 32'hF0 + i); end
    end
    n_cmp++; if (viol !== 0) begin n_err++;
      $display("FAIL final_invariant: got %0d violations want 0", viol); end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_toggle();
    test_en_drop();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
